// File: rtl/imem_loadable_pkg.sv
// Shared defaults, NOP encoding and loader state encoding for the loadable instruction memory.
// The optional misaligned-fetch trap is enabled with IMEM_ALIGN_TRAP_EN (see imem_loadable.sv).
package imem_loadable_pkg;

    localparam int WORD_LEN_DEF      = 32;
    localparam int MEM_CELL_SIZE_DEF = 8;
    localparam int MEM_SIZE_DEF      = 1024;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_loader.sv
// Program loader: LOAD/RUN FSM, byte write pointer and write strobe into the cell array.
module imem_loader
    import imem_loadable_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic          load_last,
    output logic          load_ready,
    output logic          load_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr
);

    imem_state_e   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        load_ready = (state_q == ST_LOAD);
        load_done  = (state_q == ST_RUN);
        // A byte arriving while reset is asserted must not reach the array.
        wr_en      = load_ready & load_valid & rst;
        wr_addr    = ptr_q;
        case (state_q)
            ST_LOAD: begin
                if (wr_en) begin
                    ptr_d = ptr_q + AW'(1);
                    if (load_last || (ptr_q == AW'(MEM_SIZE - 1))) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                ptr_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/imem_loadable.sv
// Loadable byte-cell instruction memory with registered big-endian fetch and stall hold.
// Define IMEM_ALIGN_TRAP_EN to return NOP plus fetch_err on misaligned fetches.
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int WORD_LEN      = WORD_LEN_DEF,
    parameter int MEM_CELL_SIZE = MEM_CELL_SIZE_DEF,
    parameter int MEM_SIZE      = MEM_SIZE_DEF,
    parameter int AW            = $clog2(MEM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [MEM_CELL_SIZE-1:0] load_byte,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    input  logic                     fetch_req,
    input  logic [WORD_LEN-1:0]      fetch_addr,
    input  logic                     fetch_stall,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
`ifdef IMEM_ALIGN_TRAP_EN
    output logic                     fetch_err,
`endif
    output logic [WORD_LEN-1:0]      fetch_instr
);

    localparam int            BPW      = WORD_LEN / MEM_CELL_SIZE;
    localparam logic [AW-1:0] OFF_MASK = AW'(BPW - 1);

    logic [MEM_CELL_SIZE-1:0] mem [MEM_SIZE];

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       cell_idx;
    logic [AW-1:0]       base_idx;
    logic [WORD_LEN-1:0] rd_word;
    logic                fetch_accept;
    logic                unused_addr_bits;

    logic                valid_q, valid_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;

    imem_loader #(
        .MEM_SIZE (MEM_SIZE),
        .AW       (AW)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= load_byte;
        end
    end

    assign cell_idx         = fetch_addr[AW-1:0];
    assign unused_addr_bits = ^fetch_addr[WORD_LEN-1:AW];
    assign fetch_ready      = load_done & ~fetch_stall & ~load_start;
    assign fetch_accept     = fetch_ready & fetch_req;

`ifdef IMEM_ALIGN_TRAP_EN
    logic misaligned;
    logic err_q, err_d;
    assign base_idx   = cell_idx;
    assign misaligned = |(cell_idx & OFF_MASK);
`else
    assign base_idx   = cell_idx & ~OFF_MASK;
`endif

    // Lowest-addressed cell lands in the MSBs; indices wrap at the top of the array.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BPW; k++) begin
            rd_word[WORD_LEN-1-k*MEM_CELL_SIZE -: MEM_CELL_SIZE] = mem[base_idx + AW'(k)];
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
`ifdef IMEM_ALIGN_TRAP_EN
        err_d   = err_q;
`endif
        if (!fetch_stall) begin
            valid_d = fetch_accept;
            if (fetch_accept) begin
                instr_d = rd_word;
            end
`ifdef IMEM_ALIGN_TRAP_EN
            err_d = fetch_accept & misaligned;
            if (fetch_accept && misaligned) begin
                instr_d = WORD_LEN'(NOP_INSTR);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
`ifdef IMEM_ALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
`ifdef IMEM_ALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
`ifdef IMEM_ALIGN_TRAP_EN
    assign fetch_err   = err_q;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed + randomized bench for imem_loadable against a byte-array reference model.
module tb_imem_loadable;

    localparam int MEM = 1024;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        err_obs;
`ifdef IMEM_ALIGN_TRAP_EN
    logic        fetch_err;
    assign err_obs = fetch_err;
`else
    assign err_obs = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [MEM];
    int         model_ptr;
    logic [31:0] held_instr;

    imem_loadable dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
`ifdef IMEM_ALIGN_TRAP_EN
        .fetch_err   (fetch_err),
`endif
        .fetch_instr (fetch_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian word at a byte address, aliasing modulo the array size.
    function automatic logic [31:0] modelWord(input logic [31:0] addr);
        int idx;
        logic [31:0] w;
        idx = int'(addr % MEM);
`ifdef IMEM_ALIGN_TRAP_EN
        if (idx % 4 != 0) return 32'h0;
`else
        idx = idx - (idx % 4);
`endif
        w = 32'h0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(model_mem[(idx + k) % MEM]);
        return w;
    endfunction

    function automatic logic modelErr(input logic [31:0] addr);
`ifdef IMEM_ALIGN_TRAP_EN
        return (addr % 4) != 0;
`else
        return (addr % 4) != 0 && 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ls, input logic lv, input logic [7:0] lb, input logic ll,
                                 input logic fr, input logic [31:0] fa, input logic fs);
        load_start  = ls;
        load_valid  = lv;
        load_byte   = lb;
        load_last   = ll;
        fetch_req   = fr;
        fetch_addr  = fa;
        fetch_stall = fs;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] b, input logic last);
        applyStimulus(1'b0, 1'b1, b, last, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("load_ready_while_loading", 32'(load_ready), 32'd1);
        stepEdge();
        model_mem[model_ptr] = b;
        model_ptr++;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic doFetch(input logic [31:0] addr, input string tag);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, addr, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        stepEdge();
        checkOutput({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        checkOutput({tag, "_instr"}, fetch_instr, modelWord(addr));
        checkOutput({tag, "_err"}, 32'(err_obs), 32'(modelErr(addr)));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic restartLoad();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        stepEdge();
        model_ptr = 0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [7:0] prog [8];
        logic [7:0] b0, b1;
        logic [31:0] a;
        prog = '{8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00};
        model_ptr = 0;

        // Reset state
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        stepEdge();
        checkOutput("reset_valid", 32'(fetch_valid), 32'd0);
        checkOutput("reset_instr", fetch_instr, 32'h0);
        checkOutput("reset_err", 32'(err_obs), 32'd0);
        checkOutput("reset_load_ready", 32'(load_ready), 32'd1);
        checkOutput("reset_load_done", 32'(load_done), 32'd0);
        rst = 1'b1;
        stepEdge();

        // 8-byte program, load_last on the final byte
        for (int i = 0; i < 8; i++) begin
            checkOutput("done_low_during_load", 32'(load_done), 32'd0);
            loadByte(prog[i], i == 7);
        end
        checkOutput("load_done_after_last", 32'(load_done), 32'd1);
        checkOutput("load_ready_in_run", 32'(load_ready), 32'd0);

        // Back-to-back fetches at 0 and 4
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_ready0", 32'(fetch_ready), 32'd1);
        stepEdge();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd4, 1'b0);
        checkOutput("b2b_valid0", 32'(fetch_valid), 32'd1);
        checkOutput("b2b_instr0", fetch_instr, 32'h8020000A);
        @(negedge clk);
        checkOutput("b2b_ready1", 32'(fetch_ready), 32'd1);
        stepEdge();
        checkOutput("b2b_valid1", 32'(fetch_valid), 32'd1);
        checkOutput("b2b_instr1", fetch_instr, 32'h04400800);

        // Stall for 3 cycles with a pending request: output holds
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b1);
            @(negedge clk);
            checkOutput("stall_ready", 32'(fetch_ready), 32'd0);
            stepEdge();
            checkOutput("stall_valid", 32'(fetch_valid), 32'd1);
            checkOutput("stall_instr", fetch_instr, 32'h04400800);
        end
        doFetch(32'd0, "post_stall");

        // Idle cycle: valid drops, data holds
        held_instr = modelWord(32'd0);
        stepEdge();
        checkOutput("idle_valid", 32'(fetch_valid), 32'd0);
        checkOutput("idle_instr", fetch_instr, held_instr);

        // Random aliased fetches into the loaded words
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, 1) * 4) + (32'($urandom_range(0, 15)) << 10);
            doFetch(a, "alias_rand");
        end

        // load_start beats fetch_req
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("ls_fetch_ready", 32'(fetch_ready), 32'd0);
        stepEdge();
        model_ptr = 0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("ls_valid_drop", 32'(fetch_valid), 32'd0);
        checkOutput("ls_load_ready", 32'(load_ready), 32'd1);
        checkOutput("ls_load_done", 32'(load_done), 32'd0);
        loadByte(8'hDE, 1'b0);
        loadByte(8'hAD, 1'b0);
        loadByte(8'hBE, 1'b0);
        loadByte(8'hEF, 1'b1);
        doFetch(32'd0, "reload_deadbeef");
        checkOutput("reload_const", fetch_instr, 32'hDEADBEEF);
        doFetch(32'd4, "reload_kept");

        // Reset in the middle of a load; the next byte lands at cell 0
        restartLoad();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        loadByte(b0, 1'b0);
        loadByte(b1, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 32'h0, 1'b0);
        stepEdge();
        rst = 1'b1;
        model_ptr = 0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_load_done", 32'(load_done), 32'd0);
        checkOutput("midrst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("midrst_valid", 32'(fetch_valid), 32'd0);
        loadByte(8'h5A, 1'b1);
        doFetch(32'd0, "midrst_cell0");

        // Fill the whole array without load_last
        restartLoad();
        for (int i = 0; i < MEM; i++) begin
            if (i == MEM - 1) checkOutput("full_not_done_yet", 32'(load_done), 32'd0);
            loadByte(8'($urandom), 1'b0);
        end
        checkOutput("full_done", 32'(load_done), 32'd1);
        doFetch(32'(MEM - 2), "full_top_wrap");
        doFetch(32'(MEM - 4), "full_top_word");
        doFetch(32'(MEM + 4), "full_alias");
        checkOutput("full_alias_vs_4", fetch_instr, modelWord(32'd4));
        doFetch(32'd2, "misaligned_2");
        for (int i = 0; i < 10; i++) begin
            doFetch($urandom, "full_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
